// File: rtl/tgmux_pkg.sv
// Shared types and constants for the transmission-gate break-before-make mux controller.
// Gate polarity lives here so the controller only reasons about "closed" vs "open".
package tgmux_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_BREAK  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_ON     = 2'd3
    } tgmux_state_e;

    localparam logic GATE_CLOSED_N = 1'b1;
    localparam logic GATE_CLOSED_P = 1'b0;

    // Delay counter width: large enough to hold the longer of the two delays.
    function automatic int cnt_width(input int dead_cyc, input int settle_cyc);
        int max_v;
        max_v = (dead_cyc > settle_cyc) ? dead_cyc : settle_cyc;
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/tgmux_delay_cnt.sv
// Loadable down-counter shared by the BREAK and SETTLE phases.
// It saturates at zero; done is asserted whenever the count is zero.
module tgmux_delay_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_r;

    // Load has priority over counting; the count holds at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/tgmux_bbm_ctrl.sv
// Break-before-make controller for a bank of CMOS transmission gates: one gate closed at a time,
// a dead time with all gates open between channels, and a settle window before SETTLED.
module tgmux_bbm_ctrl
    import tgmux_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DEAD_CYC   = 2,
    parameter int SETTLE_CYC = 3,
    parameter int SEL_W      = $clog2(N_CH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             REQ_VALID,
    input  logic             REQ_OFF,
    input  logic [SEL_W-1:0] REQ_CH,
    output logic             REQ_READY,
    output logic [N_CH-1:0]  CKN,
    output logic [N_CH-1:0]  CKP,
    output logic [SEL_W-1:0] ACTIVE_CH,
    output logic             CH_VALID,
    output logic             SETTLED,
    output logic             ERR
);

    localparam int                CNT_W     = cnt_width(DEAD_CYC, SETTLE_CYC);
    localparam logic [CNT_W-1:0]  DEAD_LD   = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W:0]    N_CH_L    = (SEL_W + 1)'(N_CH);
    localparam logic [N_CH-1:0]   GATE_ONE  = {{(N_CH - 1){1'b0}}, 1'b1};

    tgmux_state_e     state_r;
    logic [N_CH-1:0]  gate_r;
    logic [SEL_W-1:0] active_r;
    logic [SEL_W-1:0] tgt_r;
    logic             tgt_off_r;
    logic             ch_valid_r;
    logic             settled_r;
    logic             err_r;

    logic             ready_s;
    logic             accept_s;
    logic             in_range_s;
    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_val_s;
    logic             cnt_done_s;

    // Requests are only taken in the two stable states.
    always_comb begin
        ready_s = 1'b0;
        if (!RST && EN && (state_r == ST_OFF || state_r == ST_ON)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    assign accept_s   = REQ_VALID && ready_s;
    assign in_range_s = ({1'b0, REQ_CH} < N_CH_L);

    // Arm the delay counter on every transition into BREAK or SETTLE.
    always_comb begin
        cnt_load_s = 1'b0;
        cnt_val_s  = SETTLE_LD;
        case (state_r)
            ST_OFF: begin
                if (accept_s && !REQ_OFF && in_range_s) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = SETTLE_LD;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            ST_ON: begin
                if (accept_s && (REQ_OFF || (in_range_s && REQ_CH != active_r))) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = DEAD_LD;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            ST_BREAK: begin
                if (EN && cnt_done_s && !tgt_off_r) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = SETTLE_LD;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            default: begin
                cnt_load_s = 1'b0;
            end
        endcase
    end

    tgmux_delay_cnt #(
        .W (CNT_W)
    ) u_delay_cnt (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .done     (cnt_done_s)
    );

    // Sequencer: reset, then enable-drop, then the per-state behaviour.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_OFF;
            gate_r     <= {N_CH{1'b0}};
            active_r   <= {SEL_W{1'b0}};
            tgt_r      <= {SEL_W{1'b0}};
            tgt_off_r  <= 1'b0;
            ch_valid_r <= 1'b0;
            settled_r  <= 1'b0;
            err_r      <= 1'b0;
        end else if (!EN) begin
            state_r    <= ST_OFF;
            gate_r     <= {N_CH{1'b0}};
            tgt_off_r  <= 1'b0;
            ch_valid_r <= 1'b0;
            settled_r  <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                ST_OFF: begin
                    if (accept_s && !REQ_OFF) begin
                        if (in_range_s) begin
                            state_r    <= ST_SETTLE;
                            gate_r     <= GATE_ONE << REQ_CH;
                            active_r   <= REQ_CH;
                            ch_valid_r <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_ON: begin
                    if (accept_s) begin
                        if (REQ_OFF) begin
                            state_r    <= ST_BREAK;
                            gate_r     <= {N_CH{1'b0}};
                            tgt_off_r  <= 1'b1;
                            ch_valid_r <= 1'b0;
                            settled_r  <= 1'b0;
                        end else if (!in_range_s) begin
                            err_r <= 1'b1;
                        end else if (REQ_CH != active_r) begin
                            state_r    <= ST_BREAK;
                            gate_r     <= {N_CH{1'b0}};
                            tgt_r      <= REQ_CH;
                            tgt_off_r  <= 1'b0;
                            ch_valid_r <= 1'b0;
                            settled_r  <= 1'b0;
                        end
                    end
                end
                ST_BREAK: begin
                    if (cnt_done_s) begin
                        if (tgt_off_r) begin
                            state_r <= ST_OFF;
                        end else begin
                            state_r    <= ST_SETTLE;
                            gate_r     <= GATE_ONE << tgt_r;
                            active_r   <= tgt_r;
                            ch_valid_r <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_done_s) begin
                        state_r   <= ST_ON;
                        settled_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_OFF;
                    gate_r     <= {N_CH{1'b0}};
                    ch_valid_r <= 1'b0;
                    settled_r  <= 1'b0;
                end
            endcase
        end
    end

    // Both gate rails derive from one closed-mask register, so they can never disagree.
    always_comb begin
        CKN = {N_CH{~GATE_CLOSED_N}};
        CKP = {N_CH{~GATE_CLOSED_P}};
        for (int i = 0; i < N_CH; i++) begin
            CKN[i] = gate_r[i] ? GATE_CLOSED_N : ~GATE_CLOSED_N;
            CKP[i] = gate_r[i] ? GATE_CLOSED_P : ~GATE_CLOSED_P;
        end
    end

    assign REQ_READY = ready_s;
    assign ACTIVE_CH = active_r;
    assign CH_VALID  = ch_valid_r;
    assign SETTLED   = settled_r;
    assign ERR       = err_r;

endmodule

// File: tb/tb_tgmux_bbm_ctrl.sv
// Scoreboard bench for tgmux_bbm_ctrl: expectations are queued with their due cycle as stimulus
// is driven and compared on the falling edge of that cycle.
module tb_tgmux_bbm_ctrl;

    localparam int N_CH = 4, DEAD_CYC = 2, SETTLE_CYC = 3, SEL_W = 3;
    localparam int S_CKN = 0, S_SETTLED = 1, S_VALID = 2, S_ERR = 3, S_READY = 4, S_ACTIVE = 5, S_CKP = 6;

    logic             CLK = 1'b0;
    logic             RST, EN, REQ_VALID, REQ_OFF;
    logic [SEL_W-1:0] REQ_CH;
    logic             REQ_READY, CH_VALID, SETTLED, ERR;
    logic [N_CH-1:0]  CKN, CKP;
    logic [SEL_W-1:0] ACTIVE_CH;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   onehot_viol = 0;
    int   inv_viol = 0;
    logic started = 1'b0;

    tgmux_bbm_ctrl #(
        .N_CH(N_CH), .DEAD_CYC(DEAD_CYC), .SETTLE_CYC(SETTLE_CYC), .SEL_W(SEL_W)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .REQ_VALID(REQ_VALID), .REQ_OFF(REQ_OFF),
        .REQ_CH(REQ_CH), .REQ_READY(REQ_READY), .CKN(CKN), .CKP(CKP),
        .ACTIVE_CH(ACTIVE_CH), .CH_VALID(CH_VALID), .SETTLED(SETTLED), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    assert property (@(posedge CLK) disable iff (!started) $onehot0(CKN));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic expect_at(input int rel, input int sig, input logic [31:0] val, input string tag);
        exp_t e;
        e.cyc = cyc + rel;
        e.sig = sig;
        e.val = val;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_CKN:     observe = 32'(CKN);
            S_SETTLED: observe = 32'(SETTLED);
            S_VALID:   observe = 32'(CH_VALID);
            S_ERR:     observe = 32'(ERR);
            S_READY:   observe = 32'(REQ_READY);
            S_ACTIVE:  observe = 32'(ACTIVE_CH);
            S_CKP:     observe = 32'(CKP);
            default:   observe = 32'hDEADBEEF;
        endcase
    endfunction

    always @(negedge CLK) begin : mon
        exp_t e;
        if (started) begin
            if (!$onehot0(CKN)) onehot_viol++;
            if (CKP !== ~CKN) inv_viol++;
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (e.cyc < cyc) chk({e.tag, "_late"}, 32'(cyc), 32'(e.cyc));
            else chk(e.tag, observe(e.sig), e.val);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; EN = 1'b1; REQ_VALID = 1'b0; REQ_OFF = 1'b0; REQ_CH = 3'd0;
        step(); step();
        started = 1'b1;
        expect_at(0, S_CKN, 32'h0, "rst_ckn");
        expect_at(0, S_CKP, 32'hF, "rst_ckp");
        expect_at(0, S_ACTIVE, 32'd0, "rst_active");
        expect_at(0, S_VALID, 32'd0, "rst_chvalid");
        expect_at(0, S_SETTLED, 32'd0, "rst_settled");
        expect_at(0, S_ERR, 32'd0, "rst_err");
        expect_at(0, S_READY, 32'd0, "rst_ready");
        drain();

        // Reset release, then open channel 2 from OFF.
        step();
        RST = 1'b0; REQ_VALID = 1'b1; REQ_CH = 3'd2;
        expect_at(0, S_READY, 32'd1, "a_ready_off");
        expect_at(1, S_CKN, 32'b0100, "a_ckn");
        expect_at(1, S_VALID, 32'd1, "a_chvalid");
        expect_at(1, S_ACTIVE, 32'd2, "a_active");
        expect_at(1, S_SETTLED, 32'd0, "a_settled_early");
        expect_at(1, S_READY, 32'd0, "a_ready_settle");
        expect_at(3, S_SETTLED, 32'd0, "a_settled_c3");
        expect_at(4, S_SETTLED, 32'd1, "a_settled_c4");
        expect_at(4, S_READY, 32'd1, "a_ready_on");
        step(); REQ_VALID = 1'b0;
        drain();

        // Switch ch2 -> ch0, with request changes during BREAK ignored.
        step();
        REQ_VALID = 1'b1; REQ_CH = 3'd0;
        expect_at(0, S_READY, 32'd1, "b_ready_on");
        expect_at(1, S_CKN, 32'h0, "b_ckn_c1");
        expect_at(1, S_VALID, 32'd0, "b_chvalid_c1");
        expect_at(1, S_SETTLED, 32'd0, "b_settled_c1");
        expect_at(2, S_CKN, 32'h0, "b_ckn_c2");
        expect_at(2, S_READY, 32'd0, "b_ready_c2");
        expect_at(3, S_CKN, 32'b0001, "b_ckn_c3");
        expect_at(3, S_ACTIVE, 32'd0, "b_active_c3");
        expect_at(3, S_VALID, 32'd1, "b_chvalid_c3");
        expect_at(5, S_SETTLED, 32'd0, "b_settled_c5");
        expect_at(6, S_SETTLED, 32'd1, "b_settled_c6");
        expect_at(6, S_CKN, 32'b0001, "b_ckn_c6");
        step(); REQ_CH = 3'd3;
        step();
        step(); REQ_VALID = 1'b0;
        drain();

        // Same-channel request in ON is a no-op.
        step();
        REQ_VALID = 1'b1; REQ_CH = 3'd0;
        expect_at(1, S_CKN, 32'b0001, "c_ckn");
        expect_at(1, S_SETTLED, 32'd1, "c_settled");
        expect_at(1, S_VALID, 32'd1, "c_chvalid");
        expect_at(1, S_READY, 32'd1, "c_ready");
        expect_at(1, S_ERR, 32'd0, "c_err");
        expect_at(2, S_CKN, 32'b0001, "c_ckn_c2");
        step(); REQ_VALID = 1'b0;
        drain();

        // Out-of-range channel in ON: one-cycle ERR, gates unchanged.
        step();
        REQ_VALID = 1'b1; REQ_CH = 3'd5;
        expect_at(1, S_ERR, 32'd1, "d_err_pulse");
        expect_at(1, S_CKN, 32'b0001, "d_ckn_c1");
        expect_at(1, S_SETTLED, 32'd1, "d_settled");
        expect_at(2, S_ERR, 32'd0, "d_err_clear");
        expect_at(2, S_CKN, 32'b0001, "d_ckn_c2");
        step(); REQ_VALID = 1'b0;
        drain();

        // Move to ch1, then request OFF while ON.
        step();
        REQ_VALID = 1'b1; REQ_CH = 3'd1;
        expect_at(1, S_CKN, 32'h0, "e_ckn_break");
        expect_at(3, S_CKN, 32'b0010, "e_ckn_ch1");
        expect_at(3, S_ACTIVE, 32'd1, "e_active");
        expect_at(6, S_SETTLED, 32'd1, "e_settled");
        step(); REQ_VALID = 1'b0;
        drain();
        step();
        REQ_VALID = 1'b1; REQ_OFF = 1'b1; REQ_CH = 3'd3;
        expect_at(1, S_CKN, 32'h0, "off_ckn_c1");
        expect_at(1, S_READY, 32'd0, "off_ready_c1");
        expect_at(1, S_VALID, 32'd0, "off_chvalid_c1");
        expect_at(1, S_SETTLED, 32'd0, "off_settled_c1");
        expect_at(2, S_READY, 32'd0, "off_ready_c2");
        expect_at(2, S_CKN, 32'h0, "off_ckn_c2");
        expect_at(3, S_READY, 32'd1, "off_ready_c3");
        expect_at(3, S_CKN, 32'h0, "off_ckn_c3");
        expect_at(4, S_CKN, 32'h0, "off_ckn_c4");
        expect_at(4, S_VALID, 32'd0, "off_chvalid_c4");
        step(); REQ_VALID = 1'b0; REQ_OFF = 1'b0;
        drain();

        // REQ_OFF and out-of-range while already OFF.
        step();
        REQ_VALID = 1'b1; REQ_OFF = 1'b1;
        expect_at(1, S_CKN, 32'h0, "f_ckn");
        expect_at(1, S_READY, 32'd1, "f_ready");
        expect_at(1, S_VALID, 32'd0, "f_chvalid");
        expect_at(1, S_ERR, 32'd0, "f_err");
        step(); REQ_VALID = 1'b0; REQ_OFF = 1'b0;
        drain();
        step();
        REQ_VALID = 1'b1; REQ_CH = 3'd7;
        expect_at(1, S_ERR, 32'd1, "f2_err_pulse");
        expect_at(1, S_CKN, 32'h0, "f2_ckn");
        expect_at(1, S_READY, 32'd1, "f2_ready");
        expect_at(2, S_ERR, 32'd0, "f2_err_clear");
        step(); REQ_VALID = 1'b0;
        drain();

        // EN drop during SETTLE, then a request as EN returns.
        step();
        REQ_VALID = 1'b1; REQ_CH = 3'd3;
        expect_at(1, S_CKN, 32'b1000, "g_ckn_c1");
        expect_at(1, S_ACTIVE, 32'd3, "g_active_c1");
        expect_at(2, S_CKN, 32'b1000, "g_ckn_c2");
        expect_at(2, S_READY, 32'd0, "g_ready_en_low");
        expect_at(3, S_CKN, 32'h0, "g_ckn_c3");
        expect_at(3, S_VALID, 32'd0, "g_chvalid_c3");
        expect_at(3, S_SETTLED, 32'd0, "g_settled_c3");
        expect_at(3, S_READY, 32'd1, "g_ready_c3");
        expect_at(4, S_CKN, 32'b0010, "g_ckn_c4");
        expect_at(4, S_ACTIVE, 32'd1, "g_active_c4");
        expect_at(6, S_SETTLED, 32'd0, "g_settled_c6");
        expect_at(7, S_SETTLED, 32'd1, "g_settled_c7");
        step(); REQ_VALID = 1'b0;
        step(); EN = 1'b0;
        step(); EN = 1'b1; REQ_VALID = 1'b1; REQ_CH = 3'd1;
        step(); REQ_VALID = 1'b0;
        drain();

        // EN low beats a simultaneous request in ON.
        step();
        EN = 1'b0; REQ_VALID = 1'b1; REQ_CH = 3'd2;
        expect_at(0, S_READY, 32'd0, "h_ready_en_low");
        expect_at(1, S_CKN, 32'h0, "h_ckn_c1");
        expect_at(1, S_VALID, 32'd0, "h_chvalid_c1");
        expect_at(1, S_SETTLED, 32'd0, "h_settled_c1");
        expect_at(1, S_ERR, 32'd0, "h_err_c1");
        expect_at(2, S_CKN, 32'h0, "h_ckn_c2");
        expect_at(2, S_READY, 32'd1, "h_ready_c2");
        step(); EN = 1'b1; REQ_VALID = 1'b0;
        drain();

        // Reset pulse during BREAK discards the pending channel.
        step();
        REQ_VALID = 1'b1; REQ_CH = 3'd2;
        expect_at(4, S_SETTLED, 32'd1, "i_settled_ch2");
        step(); REQ_VALID = 1'b0;
        drain();
        step();
        REQ_VALID = 1'b1; REQ_CH = 3'd0;
        expect_at(1, S_CKN, 32'h0, "i_ckn_break");
        expect_at(1, S_READY, 32'd0, "i_ready_rst");
        expect_at(2, S_CKN, 32'h0, "i_ckn_rst");
        expect_at(2, S_CKP, 32'hF, "i_ckp_rst");
        expect_at(2, S_ACTIVE, 32'd0, "i_active_rst");
        expect_at(2, S_VALID, 32'd0, "i_chvalid_rst");
        expect_at(2, S_SETTLED, 32'd0, "i_settled_rst");
        expect_at(2, S_ERR, 32'd0, "i_err_rst");
        expect_at(2, S_READY, 32'd1, "i_ready_after");
        expect_at(3, S_CKN, 32'h0, "i_ckn_c3");
        expect_at(4, S_CKN, 32'h0, "i_ckn_c4");
        expect_at(5, S_CKN, 32'h0, "i_ckn_c5");
        expect_at(5, S_VALID, 32'd0, "i_chvalid_c5");
        step(); REQ_VALID = 1'b0; RST = 1'b1;
        step(); RST = 1'b0;
        drain();

        step();
        chk("onehot_ckn", 32'(onehot_viol), 32'd0);
        chk("ckp_inverse", 32'(inv_viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tgmux_bbm_ctrl.md
TGMUX_BBM_CTRL -- requirements
Module: tgmux_bbm_ctrl

Interface
REQ-001 Parameters SHALL be:
- N_CH, default 4, number of transmission-gate channels (2..16).
- DEAD_CYC, default 2, break-before-make dead time in cycles (>=1).
- SETTLE_CYC, default 3, settle cycles after a gate closes (>=1).
- SEL_W, default $clog2(N_CH), request index width.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous active-high reset.
- EN  in  1  global enable; low forces all gates open.
- REQ_VALID  in  1  request present.
- REQ_OFF  in  1  request is "open all gates"; REQ_CH is ignored.
- REQ_CH  in  SEL_W  requested channel index.
- REQ_READY  out  1  request accepted when REQ_VALID and REQ_READY are both high.
- CKN  out  N_CH  NMOS gate controls, 1 = closed.
- CKP  out  N_CH  PMOS gate controls, 0 = closed.
- ACTIVE_CH  out  SEL_W  index of the closed or closing channel.
- CH_VALID  out  1  a channel is closed.
- SETTLED  out  1  the closed channel has completed SETTLE_CYC.
- ERR  out  1  one-cycle pulse on an accepted out-of-range REQ_CH.

Function
REQ-004 The FSM SHALL have states OFF, BREAK, SETTLE and ON.
REQ-005 REQ_READY SHALL be high only in OFF or ON with EN high.
REQ-006 For every channel i, CKP[i] SHALL equal ~CKN[i] in every cycle.
REQ-007 At most one CKN bit SHALL be high in any cycle.
REQ-008 OFF + accepted valid REQ_CH=k SHALL go to SETTLE next cycle, with CKN[k]=1, ACTIVE_CH=k and CH_VALID=1.
REQ-009 SETTLE SHALL count SETTLE_CYC cycles, then enter ON; SETTLED SHALL rise on ON entry, i.e. SETTLE_CYC+1 cycles after acceptance.
REQ-010 ON + accepted REQ_CH=j, with j different from ACTIVE_CH, SHALL go to BREAK next cycle with all CKN=0, CH_VALID=0 and SETTLED=0.
REQ-011 BREAK SHALL hold all gates open for exactly DEAD_CYC cycles, then enter SETTLE with CKN[j]=1.
REQ-012 ON + accepted REQ_CH equal to ACTIVE_CH SHALL cause no state or output change.
REQ-013 An accepted REQ_OFF in ON SHALL open all gates next cycle and go to BREAK; BREAK then ends in OFF.
REQ-014 An accepted REQ_OFF in OFF SHALL be a no-op.
REQ-015 An accepted REQ_CH >= N_CH SHALL pulse ERR for 1 cycle and otherwise be ignored.
REQ-016 The pending target SHALL be latched on acceptance; REQ_* changes during BREAK or SETTLE SHALL be ignored.
REQ-017 EN low in any state SHALL, on the next cycle, open all gates, clear CH_VALID and SETTLED, and enter OFF, discarding any pending target.
REQ-018 EN low SHALL take priority over a simultaneous request.
REQ-019 Counters SHALL be wide enough for max(DEAD_CYC, SETTLE_CYC) with no wrap-around.

Reset
REQ-020 RST high SHALL, on the next CLK edge, force state OFF, CKN all 0, CKP all 1, ACTIVE_CH 0, CH_VALID 0, SETTLED 0, ERR 0 and counters 0.
REQ-021 REQ_READY SHALL be 0 while RST is high.
REQ-022 RST SHALL override EN and requests.
REQ-023 Reset mid-BREAK or mid-SETTLE SHALL discard the pending target.

Structure
REQ-024 Package tgmux_pkg SHALL hold the state enum and the gate-encoding constants (GATE_CLOSED_N=1, GATE_CLOSED_P=0).
REQ-025 One sub-module, tgmux_delay_cnt, SHALL implement a loadable down-counter with a done flag, shared by BREAK and SETTLE.

Verification (N_CH=4, DEAD_CYC=2, SETTLE_CYC=3)
REQ-026 Reset release then REQ_CH=2 at cycle 0 -> CKN=0100 at cycle 1, SETTLED=1 at cycle 4.
REQ-027 From ON ch2, REQ_CH=0 at cycle 0 -> CKN=0000 at cycles 1-2, CKN=0001 at cycle 3, SETTLED at cycle 6; assertion that at most one CKN bit is ever set.
REQ-028 REQ_CH=5 (out of range) -> ERR=1 for exactly 1 cycle, CKN unchanged.
REQ-029 EN=0 during SETTLE -> CKN=0000 next cycle, state OFF; a request at EN's re-rise opens from OFF.
REQ-030 RST pulse during BREAK -> all outputs at reset values next cycle, pending channel never closes.
REQ-031 REQ_OFF while ON ch1 -> CKN=0000 next cycle, REQ_READY low for 2 cycles, then OFF with REQ_READY=1.
